// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access unit for the execute/memory stage. Accepts a load or
// store from the decoder, issues a single req/gnt/rvalid DMEM transaction with
// lane-aligned byte enables and write data, and returns sign/zero-extended
// load data. The pipeline is stalled while the access is in flight.
//
// Ports
//   clk_i, rst_ni                   clock, async active-low reset
//   mem_read_i, mem_write_i         load / store request (store wins)
//   d_size_i                        0001 byte, 0011 half, 1111 word
//   d_unsigned_i                    zero-extend load result
//   dma_en_i                        DMA store: implies write, forces word size
//   addr_i, wdata_i                 byte address, store data (low bits)
//   stall_o                         hold pipeline
//   rdata_o, rdata_valid_o          extended load result, valid strobe
//   misaligned_o                    misaligned access flag
//   dmem_req_o .. dmem_wdata_o      DMEM request side
//   dmem_gnt_i, dmem_rvalid_i,
//   dmem_rdata_i                    DMEM response side
//
// Build option: define LSU_MISALIGN_CHECK_EN to flag misaligned/illegal-size
// accesses instead of silently aligning them.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [3:0]            d_size_i,
   input  logic                  d_unsigned_i,
   input  logic                  dma_en_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  stall_o,
   output logic [31:0]           rdata_o,
   output logic                  rdata_valid_o,
   output logic                  misaligned_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [3:0]            dmem_be_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [31:0]           dmem_wdata_o,
   input  logic                  dmem_gnt_i,
   input  logic                  dmem_rvalid_i,
   input  logic [31:0]           dmem_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e                state_q, state_d;
   logic                  we_q, we_d;
   logic [3:0]            be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [1:0]            off_q, off_d;
   logic                  uns_q, uns_d;
   logic [3:0]            size_q, size_d;

   logic access, mis, accept;
   logic [31:0] shifted, ext;

   assign access = mem_read_i | mem_write_i | dma_en_i;

   // Request decode. Illegal size masks fall back to word.
   always_comb begin
      size_d = 4'b1111;
      if (!dma_en_i && (d_size_i == 4'b0001 || d_size_i == 4'b0011))
         size_d = d_size_i;
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic illegal;
   assign illegal = !dma_en_i && !(d_size_i == 4'b0001 || d_size_i == 4'b0011 ||
                                   d_size_i == 4'b1111);
   assign mis = illegal
              | ((size_d == 4'b0011) && addr_i[0])
              | ((size_d == 4'b1111) && (addr_i[1:0] != 2'b00));
   assign off_d = addr_i[1:0];
`else
   // No checking: drop the address bits that cannot be legal for the size.
   assign mis   = 1'b0;
   assign off_d = (size_d == 4'b1111) ? 2'b00 :
                  (size_d == 4'b0011) ? {addr_i[1], 1'b0} : addr_i[1:0];
`endif

   assign we_d   = mem_write_i | dma_en_i;
   assign be_d   = size_d << off_d;
   assign addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign uns_d  = d_unsigned_i;

   // Replicate narrow store data so every enabled lane carries it.
   always_comb begin
      case (size_d)
         4'b0001: wdata_d = {4{wdata_i[7:0]}};
         4'b0011: wdata_d = {2{wdata_i[15:0]}};
         default: wdata_d = wdata_i;
      endcase
   end

   assign accept = (state_q == IDLE) && access && !mis;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         off_q   <= '0;
         uns_q   <= 1'b0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
         end
      end
   end

   // Load alignment and extension.
   assign shifted = dmem_rdata_i >> {off_q, 3'b000};
   always_comb begin
      case (size_q)
         4'b0001: ext = {{24{shifted[7]  & ~uns_q}}, shifted[7:0]};
         4'b0011: ext = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   // Next state and outputs. Stall drops in the completion cycle.
   always_comb begin
      state_d       = state_q;
      stall_o       = 1'b0;
      rdata_valid_o = 1'b0;
      misaligned_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (mis) begin
                  misaligned_o = 1'b1;
               end else begin
                  stall_o = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_gnt_i) begin
               if (we_q) begin
                  state_d = IDLE;
               end else begin
                  stall_o = 1'b1;
                  state_d = WAIT;
               end
            end else begin
               stall_o = 1'b1;
            end
         end
         WAIT: begin
            if (dmem_rvalid_i) begin
               rdata_valid_o = 1'b1;
               state_d       = IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdata_o      = rdata_valid_o ? ext : 32'h0;
   assign dmem_req_o   = (state_q == REQ);
   assign dmem_we_o    = we_q;
   assign dmem_be_o    = be_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Stimulus tasks push the expected DMEM
// request and load result into queues; a negedge monitor pops and compares
// whenever the DUT issues a request or presents load data.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, d_uns, dma_en;
   logic [3:0]  d_size;
   logic [31:0] addr, wdata;
   logic        stall, rdata_valid, misaligned;
   logic [31:0] rdata;
   logic        req, we, gnt, rvalid;
   logic [3:0]  be;
   logic [31:0] daddr, dwdata, drdata;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mem_read_i(mem_read), .mem_write_i(mem_write), .d_size_i(d_size),
      .d_unsigned_i(d_uns), .dma_en_i(dma_en), .addr_i(addr), .wdata_i(wdata),
      .stall_o(stall), .rdata_o(rdata), .rdata_valid_o(rdata_valid),
      .misaligned_o(misaligned),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_be_o(be), .dmem_addr_o(daddr),
      .dmem_wdata_o(dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
      .dmem_rdata_i(drdata)
   );

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [31:0] rd_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: request fields are checked every REQ cycle (so they must hold
   // stable while waiting for gnt) and the entry retires on gnt.
   always @(negedge clk) begin
      if (rst_n) begin
         if (req) begin
            if (req_q.size() == 0) begin
               total++; bad++;
               $display("FAIL req_unexpected actual=addr %h required=no request", daddr);
            end else begin
               chk("req_we", {31'b0, we}, {31'b0, req_q[0].we});
               chk("req_be", {28'b0, be}, {28'b0, req_q[0].be});
               chk("req_addr", daddr, req_q[0].addr);
               chk("req_wdata", dwdata, req_q[0].wdata);
               if (gnt) void'(req_q.pop_front());
            end
         end
         if (rdata_valid) begin
            if (rd_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rdata_unexpected actual=%h required=no data", rdata);
            end else begin
               chk("rdata", rdata, rd_q.pop_front());
            end
         end
      end
   end

   task automatic clear_inputs();
      mem_read = 0; mem_write = 0; dma_en = 0; d_uns = 0;
      d_size = 4'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after completion.
   task automatic access(input logic rd, input logic wr, input logic dm, input logic uns,
                         input logic [3:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input int gdly, input logic [31:0] rdw,
                         input logic [3:0] ebe, input logic [31:0] eaddr,
                         input logic [31:0] ewd, input logic [31:0] erd);
      req_t r;
      logic is_we;
      is_we = wr | dm;
      mem_read = rd; mem_write = wr; dma_en = dm; d_uns = uns;
      d_size = sz; addr = a; wdata = wd;
      r.we = is_we; r.be = ebe; r.addr = eaddr; r.wdata = ewd;
      req_q.push_back(r);
      @(negedge clk);
      chk("accept_stall", {31'b0, stall}, 32'd1);
      chk("accept_noreq", {31'b0, req}, 32'd0);
      chk("accept_mis", {31'b0, misaligned}, 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk);
         chk("wait_gnt_stall", {31'b0, stall}, 32'd1);
         @(posedge clk); #1;
      end
      gnt = 1;
      @(negedge clk);
      chk("gnt_stall", {31'b0, stall}, {31'b0, ~is_we});
      @(posedge clk); #1;
      gnt = 0;
      if (!is_we) begin
         rvalid = 1; drdata = rdw;
         rd_q.push_back(erd);
         @(negedge clk);
         chk("rvalid_stall", {31'b0, stall}, 32'd0);
         chk("rvalid_strobe", {31'b0, rdata_valid}, 32'd1);
         @(posedge clk); #1;
         rvalid = 0; drdata = 32'h0;
      end
      chk("done_noreq", {31'b0, req}, 32'd0);
      chk("done_novalid", {31'b0, rdata_valid}, 32'd0);
   endtask

`ifdef LSU_MISALIGN_CHECK_EN
   task automatic mis_access(input logic [3:0] sz, input logic [31:0] a);
      mem_read = 1; d_size = sz; addr = a;
      @(negedge clk);
      chk("mis_flag", {31'b0, misaligned}, 32'd1);
      chk("mis_stall", {31'b0, stall}, 32'd0);
      chk("mis_noreq", {31'b0, req}, 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk("mis_pulse_end", {31'b0, misaligned}, 32'd0);
      chk("mis_noreq2", {31'b0, req}, 32'd0);
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      rst_n = 0; gnt = 0; rvalid = 0; drdata = 32'h0;
      clear_inputs();
      #2;
      chk("rst_req", {31'b0, req}, 32'd0);
      chk("rst_we", {31'b0, we}, 32'd0);
      chk("rst_be", {28'b0, be}, 32'd0);
      chk("rst_addr", daddr, 32'd0);
      chk("rst_wdata", dwdata, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_valid", {31'b0, rdata_valid}, 32'd0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // gnt/rvalid while idle are ignored
      gnt = 1; rvalid = 1; drdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("idle_noreq", {31'b0, req}, 32'd0);
      chk("idle_nostall", {31'b0, stall}, 32'd0);
      chk("idle_novalid", {31'b0, rdata_valid}, 32'd0);
      @(posedge clk); #1;
      gnt = 0; rvalid = 0; drdata = 32'h0;

      //     rd wr dm un size     addr          wdata         g rdata          be       eaddr         ewdata        erd
      access(1, 0, 0, 0, 4'b0001, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80);
      access(1, 0, 0, 1, 4'b0011, 32'h0000_0202, 32'h0,        3, 32'hBEEF_1234, 4'b1100, 32'h0000_0200, 32'h0,        32'h0000_BEEF);
      access(0, 1, 0, 0, 4'b0001, 32'h0000_0301, 32'h0000_00AB, 0, 32'h0,        4'b0010, 32'h0000_0300, 32'hABAB_ABAB, 32'h0);
      access(0, 0, 1, 0, 4'b0000, 32'h0000_0400, 32'h1234_5678, 1, 32'h0,        4'b1111, 32'h0000_0400, 32'h1234_5678, 32'h0);
      access(0, 1, 0, 0, 4'b0011, 32'h0000_0502, 32'h0000_CAFE, 0, 32'h0,        4'b1100, 32'h0000_0500, 32'hCAFE_CAFE, 32'h0);
      access(1, 0, 0, 1, 4'b0001, 32'h0000_0002, 32'h0,        0, 32'h0080_0000, 4'b0100, 32'h0000_0000, 32'h0,        32'h0000_0080);
      // store wins over load when both are requested
      access(1, 1, 0, 0, 4'b1111, 32'h0000_0700, 32'h0102_0304, 0, 32'h0,        4'b1111, 32'h0000_0700, 32'h0102_0304, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      mis_access(4'b1111, 32'h0000_0402);
      mis_access(4'b0011, 32'h0000_0001);
      mis_access(4'b0101, 32'h0000_0004);
`else
      access(1, 0, 0, 0, 4'b1111, 32'h0000_0402, 32'h0,        0, 32'h8765_4321, 4'b1111, 32'h0000_0400, 32'h0,        32'h8765_4321);
      access(1, 0, 0, 0, 4'b0011, 32'h0000_0001, 32'h0,        0, 32'h1234_8001, 4'b0011, 32'h0000_0000, 32'h0,        32'hFFFF_8001);
      access(1, 0, 0, 0, 4'b0101, 32'h0000_0007, 32'h0,        0, 32'h0000_ABCD, 4'b1111, 32'h0000_0004, 32'h0,        32'h0000_ABCD);
`endif

      // reset during WAIT, stale rvalid afterwards must be dropped
      begin
         req_t r;
         r.we = 0; r.be = 4'b0001; r.addr = 32'h0000_0600; r.wdata = 32'h0;
         req_q.push_back(r);
         mem_read = 1; d_size = 4'b0001; addr = 32'h0000_0600; d_uns = 1;
         @(posedge clk); #1;
         clear_inputs();
         gnt = 1;
         @(posedge clk); #1;
         gnt = 0;
         #2 rst_n = 0;
         #1;
         chk("abort_noreq", {31'b0, req}, 32'd0);
         chk("abort_nostall", {31'b0, stall}, 32'd0);
         @(posedge clk); #1;
         rst_n = 1;
         rvalid = 1; drdata = 32'h0000_00FF;
         @(negedge clk);
         chk("abort_novalid", {31'b0, rdata_valid}, 32'd0);
         chk("abort_idle", {31'b0, stall}, 32'd0);
         @(posedge clk); #1;
         rvalid = 0; drdata = 32'h0;
      end
      access(1, 0, 0, 0, 4'b0011, 32'h0000_0802, 32'h0,        0, 32'h7FFF_0000, 4'b1100, 32'h0000_0800, 32'h0,        32'h0000_7FFF);

      @(negedge clk);
      chk("req_q_empty", req_q.size(), 32'd0);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit in the execute/memory stage, consuming the decoder's memory control (`mem_read`, `mem_write`, `d_size`, `d_unsigned`, `dma_en`) plus the ALU address and store data. It drives a req/gnt/rvalid DMEM port with lane-aligned byte enables and write data. It returns sign- or zero-extended load data to the write-back mux. While an access is in flight it stalls the pipeline.

## Interface
- `ADDR_WIDTH`, 32, byte address width; data path fixed at 32 bits.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `mem_read_i`  in  1  load request (decoder).
- `mem_write_i`  in  1  store request (decoder).
- `d_size_i`  in  4  size mask: 0001 byte, 0011 half, 1111 word.
- `d_unsigned_i`  in  1  zero-extend load.
- `dma_en_i`  in  1  PIM/DMA store: forces word size regardless of `d_size_i`.
- `addr_i`  in  ADDR_WIDTH  byte address.
- `wdata_i`  in  32  store data, value in low bits.
- `stall_o`  out  1  hold pipeline.
- `rdata_o`  out  32  extended load result.
- `rdata_valid_o`  out  1  `rdata_o` valid this cycle.
- `misaligned_o`  out  1  one-cycle misalignment flag.
- `dmem_req_o`  out  1  request.
- `dmem_we_o`  out  1  write enable.
- `dmem_be_o`  out  4  byte enables.
- `dmem_addr_o`  out  ADDR_WIDTH  word-aligned address, low 2 bits 0.
- `dmem_wdata_o`  out  32  lane-aligned write data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid access (`mem_read_i | mem_write_i`, not misaligned):
  - capture `we`, `be`, `addr`, `wdata`, `addr[1:0]`, `unsigned` and size into registers;
  - go to REQ.
- `mem_write_i` has priority if both request inputs are high. `dma_en_i` implies a write.
- Byte enables: `size_mask << addr[1:0]`.
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- REQ: `dmem_req_o=1` with registered `we/be/addr/wdata`, held stable until `dmem_gnt_i`.
  - On gnt, store: done, back to IDLE.
  - On gnt, load: go to WAIT.
- WAIT: on `dmem_rvalid_i`, done, back to IDLE.
  - `rdata_o` = `dmem_rdata_i >> (8*addr[1:0])`, masked to size, then sign-extended from bit 7/15 unless unsigned.
  - `rdata_valid_o=1` that cycle only.
- `stall_o` (combinational) is high when either:
  - IDLE with a valid access; or
  - non-IDLE and not completing this cycle.
- `stall_o` is low in the completion cycle: store gnt cycle, load rvalid cycle.
- No access in IDLE: `stall_o=0`, no request.
- `rvalid` outside WAIT is ignored. `gnt` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `dmem_req_o`, `dmem_we_o`, `stall_o`, `rdata_valid_o`, `misaligned_o` all 0; `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o`, `rdata_o` all 0.
- Request appears 1 cycle after the access is presented.
- Store with gnt in its first REQ cycle: 2-cycle stall window (accept cycle plus REQ cycle), stall low in the gnt cycle.
- Load with gnt in its first REQ cycle and rvalid the next cycle: stall high for 2 cycles, data in the 3rd cycle.
- Reset asserted mid-access: immediately IDLE and `dmem_req_o=0`. A later rvalid for the aborted load is ignored.
- Back-to-back accesses: the next access can be accepted the cycle after completion.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - misaligned means half with `addr[0]=1`; word/DMA with `addr[1:0]≠0`; `d_size_i` not one of the three legal masks.
  - A misaligned access pulses `misaligned_o` for 1 cycle in IDLE, issues no request, and does not stall.
- Undefined:
  - `misaligned_o` is tied 0;
  - the low address bits illegal for the size are forced to 0 (half `addr[0]`, word `addr[1:0]`);
  - an illegal `d_size_i` is treated as word.

## Test plan
- Load byte signed at `0x103`, rdata `0x80FF_0000`, gnt in first REQ cycle, rvalid 1 cycle later → `be=1000`, `dmem_addr_o=0x100`, `rdata_o=0xFFFF_FF80`, `rdata_valid_o` for 1 cycle.
- Load half unsigned at `0x202`, rdata `0xBEEF_1234`, gnt delayed 3 cycles → REQ held with stable outputs, `be=1100`, `rdata_o=0x0000_BEEF`, stall high throughout until the rvalid cycle.
- Store byte `0xAB` at `0x301` → `dmem_wdata_o=0xABAB_ABAB`, `be=0010`, `we=1`; stall drops in the gnt cycle.
- DMA store (`dma_en_i=1`, `d_size_i=0`) at `0x400`, data `0x1234_5678` → `be=1111`, data unmodified.
- With macro: word load at `0x402` → `misaligned_o=1` for 1 cycle, `dmem_req_o` stays 0, `stall_o=0`.
- Without macro: the same load → request to `0x400`, `misaligned_o=0`.
- `rst_ni` low in WAIT, rvalid arrives after release → `rdata_valid_o` stays 0, state IDLE.
